addr_reg_bank: RTL and testbench

Parametrised bank of address registers for the processor datapath, replacing the single 16-bit address register. It holds NCH independent address channels of width W. Each channel can be loaded from the A bus, cleared, or stepped up or down. A built-in burst sequencer walks one channel through consecutive memory addresses under a valid/ready handshake, so the control unit does not have to issue per-beat increments.

---
 rtl/addr_reg_pkg.sv | 20 ++
 rtl/addr_reg_bank_if.sv | 38 +++
 rtl/addr_burst_fsm.sv | 78 +++++++
 rtl/addr_reg_bank.sv | 79 +++++++
 tb/tb_addr_reg_bank.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/addr_reg_pkg.sv
// Shared types and defaults for the address register bank and its burst sequencer.
package addr_reg_pkg;

  localparam int AR_W_DEF      = 16;
  localparam int AR_NCH_DEF    = 4;
  localparam int AR_LENW_DEF   = 8;
  localparam int AR_STRIDE_DEF = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } burst_state_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } step_dir_e;

endpackage

// File: rtl/addr_reg_bank_if.sv
// Control, memory-handshake and readback signals of the address register bank.
interface addr_reg_bank_if #(
  parameter int W    = addr_reg_pkg::AR_W_DEF,
  parameter int NCH  = addr_reg_pkg::AR_NCH_DEF,
  parameter int LENW = addr_reg_pkg::AR_LENW_DEF
);
  localparam int SELW = $clog2(NCH);

  logic              wr_en;
  logic [SELW-1:0]   wr_sel;
  logic [W-1:0]      bus_in;
  logic              clr_en;
  logic [SELW-1:0]   clr_sel;
  logic              step_en;
  logic [SELW-1:0]   step_sel;
  logic              step_dn;
  logic              burst_start;
  logic [SELW-1:0]   burst_sel;
  logic [LENW-1:0]   burst_len;
  logic              mem_valid;
  logic              mem_ready;
  logic [W-1:0]      mem_addr;
  logic              burst_busy;
  logic              burst_done;
  logic [NCH*W-1:0]  ar_out;

  modport master (
    output wr_en, wr_sel, bus_in, clr_en, clr_sel, step_en, step_sel, step_dn,
           burst_start, burst_sel, burst_len, mem_ready,
    input  mem_valid, mem_addr, burst_busy, burst_done, ar_out
  );

  modport slave (
    input  wr_en, wr_sel, bus_in, clr_en, clr_sel, step_en, step_sel, step_dn,
           burst_start, burst_sel, burst_len, mem_ready,
    output mem_valid, mem_addr, burst_busy, burst_done, ar_out
  );
endinterface

// File: rtl/addr_burst_fsm.sv
// Burst sequencer: owns the beat counter and active channel, and emits one
// advance strobe per accepted beat for the register array to act on.
module addr_burst_fsm
  import addr_reg_pkg::*;
#(
  parameter int NCH  = AR_NCH_DEF,
  parameter int LENW = AR_LENW_DEF,
  parameter int SELW = $clog2(NCH)
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            burst_start,
  input  logic [SELW-1:0] burst_sel,
  input  logic [LENW-1:0] burst_len,
  input  logic            mem_ready,
  output logic            mem_valid,
  output logic            burst_busy,
  output logic            burst_done,
  output logic            adv_en,
  output logic [SELW-1:0] act_sel
);

  burst_state_e    state_reg, state_next;
  logic [LENW-1:0] cnt_reg, cnt_next;
  logic [SELW-1:0] act_reg, act_next;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      act_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      act_reg   <= act_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    act_next   = act_reg;
    mem_valid  = 1'b0;
    burst_done = 1'b0;
    adv_en     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (burst_start) begin
          // A zero-length request still completes, but never issues a beat.
          if (burst_len != '0) begin
            act_next   = burst_sel;
            cnt_next   = burst_len;
            state_next = RUN;
          end else begin
            state_next = DONE;
          end
        end
      end
      RUN: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          adv_en   = 1'b1;
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == LENW'(1)) state_next = DONE;
        end
      end
      DONE: begin
        burst_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign burst_busy = (state_reg != IDLE);
  assign act_sel    = act_reg;

endmodule

// File: rtl/addr_reg_bank.sv
// NCH-channel address register bank with load/clear/step and a burst walker.
// Build option: define AR_SAT_EN to saturate stepping instead of wrapping.
module addr_reg_bank
  import addr_reg_pkg::*;
#(
  parameter int W      = AR_W_DEF,
  parameter int NCH    = AR_NCH_DEF,
  parameter int LENW   = AR_LENW_DEF,
  parameter int STRIDE = AR_STRIDE_DEF
) (
  input logic           Clock,
  input logic           Reset,
  addr_reg_bank_if.slave bus
);

  localparam int SELW = $clog2(NCH);
  localparam logic [W-1:0] STRIDE_W = W'(STRIDE);

  logic            adv_en;
  logic [SELW-1:0] act_sel;
  logic [W-1:0]    ar_q [NCH];

  addr_burst_fsm #(
    .NCH  (NCH),
    .LENW (LENW),
    .SELW (SELW)
  ) u_fsm (
    .Clock       (Clock),
    .Reset       (Reset),
    .burst_start (bus.burst_start),
    .burst_sel   (bus.burst_sel),
    .burst_len   (bus.burst_len),
    .mem_ready   (bus.mem_ready),
    .mem_valid   (bus.mem_valid),
    .burst_busy  (bus.burst_busy),
    .burst_done  (bus.burst_done),
    .adv_en      (adv_en),
    .act_sel     (act_sel)
  );

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [W-1:0] ch_reg;
      logic [W-1:0] up_val, dn_val;

`ifdef AR_SAT_EN
      logic [W:0] up_sum, dn_diff;
      assign up_sum  = {1'b0, ch_reg} + {1'b0, STRIDE_W};
      assign dn_diff = {1'b0, ch_reg} - {1'b0, STRIDE_W};
      assign up_val  = up_sum[W]  ? '1 : up_sum[W-1:0];
      assign dn_val  = dn_diff[W] ? '0 : dn_diff[W-1:0];
`else
      assign up_val = ch_reg + STRIDE_W;
      assign dn_val = ch_reg - STRIDE_W;
`endif

      // clr beats wr beats a burst advance beats a step; other channels are independent.
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          ch_reg <= '0;
        end else if (bus.clr_en && bus.clr_sel == SELW'(gi)) begin
          ch_reg <= '0;
        end else if (bus.wr_en && bus.wr_sel == SELW'(gi)) begin
          ch_reg <= bus.bus_in;
        end else if (adv_en && act_sel == SELW'(gi)) begin
          ch_reg <= up_val;
        end else if (bus.step_en && bus.step_sel == SELW'(gi)) begin
          ch_reg <= (bus.step_dn == DIR_DN) ? dn_val : up_val;
        end
      end

      assign ar_q[gi]              = ch_reg;
      assign bus.ar_out[gi*W +: W] = ch_reg;
    end
  endgenerate

  assign bus.mem_addr = ar_q[act_sel];

endmodule

// File: tb/tb_addr_reg_bank.sv
// Scoreboarded bench for addr_reg_bank: burst beat addresses are queued when
// the stimulus is set up and checked as handshakes occur.
module tb_addr_reg_bank;

  localparam int W    = 16;
  localparam int NCH  = 4;
  localparam int LENW = 8;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  addr_reg_bank_if #(.W(W), .NCH(NCH), .LENW(LENW)) bus ();

  addr_reg_bank #(.W(W), .NCH(NCH), .LENW(LENW), .STRIDE(1)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [W-1:0] addr_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  function automatic logic [W-1:0] chan(input int k);
    return bus.ar_out[k*W +: W];
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_wr(input int sel, input logic [W-1:0] val);
    bus.wr_en  = 1'b1;
    bus.wr_sel = 2'(sel);
    bus.bus_in = val;
    tick();
    bus.wr_en  = 1'b0;
  endtask

  task automatic start_burst(input int sel, input int len);
    bus.burst_start = 1'b1;
    bus.burst_sel   = 2'(sel);
    bus.burst_len   = 8'(len);
    tick();
    bus.burst_start = 1'b0;
  endtask

  // Beat monitor: every accepted beat must match the next queued address.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (bus.mem_valid && bus.mem_ready) begin
        check("beat_expected", 64'(addr_q.size() != 0), 64'd1);
        if (addr_q.size() != 0) check("beat_addr", bus.mem_addr, addr_q.pop_front());
      end
      if (bus.burst_done) done_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.wr_en = 0; bus.wr_sel = 0; bus.bus_in = 0;
    bus.clr_en = 0; bus.clr_sel = 0;
    bus.step_en = 0; bus.step_sel = 0; bus.step_dn = 0;
    bus.burst_start = 0; bus.burst_sel = 0; bus.burst_len = 0;
    bus.mem_ready = 0;
    tick(); tick();
    Reset = 1'b0;
    check("rst_ar_out", bus.ar_out, 64'd0);
    check("rst_mem_valid", bus.mem_valid, 64'd0);
    check("rst_busy", bus.burst_busy, 64'd0);
    check("rst_done", bus.burst_done, 64'd0);

    // Asynchronous reset mid-cycle
    do_wr(1, 16'hBEEF);
    check("wr_ch1", chan(1), 16'hBEEF);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_ar", bus.ar_out, 64'd0);
    check("async_rst_valid", bus.mem_valid, 64'd0);
    check("async_rst_busy", bus.burst_busy, 64'd0);
    tick();
    Reset = 1'b0;

    // Load, clear priority, concurrent ops on different channels
    do_wr(2, 16'h1234);
    check("wr_ch2", chan(2), 16'h1234);
    bus.clr_en = 1'b1; bus.clr_sel = 2'd2;
    do_wr(2, 16'h5555);
    bus.clr_en = 1'b0;
    check("clr_over_wr", chan(2), 16'h0000);
    do_wr(3, 16'h3333);
    bus.clr_en = 1'b1; bus.clr_sel = 2'd3;
    do_wr(0, 16'hAAAA);
    bus.clr_en = 1'b0;
    check("par_wr_ch0", chan(0), 16'hAAAA);
    check("par_clr_ch3", chan(3), 16'h0000);

    // Step boundaries
    do_wr(0, 16'hFFFF);
    bus.step_en = 1'b1; bus.step_sel = 2'd0; bus.step_dn = 1'b0;
    tick();
    bus.step_en = 1'b0;
`ifdef AR_SAT_EN
    check("step_up_max", chan(0), 16'hFFFF);
`else
    check("step_up_max", chan(0), 16'h0000);
`endif
    do_wr(1, 16'h0000);
    bus.step_en = 1'b1; bus.step_sel = 2'd1; bus.step_dn = 1'b1;
    tick();
    bus.step_en = 1'b0;
`ifdef AR_SAT_EN
    check("step_dn_zero", chan(1), 16'h0000);
`else
    check("step_dn_zero", chan(1), 16'hFFFF);
`endif

    // Burst with back-pressure
    do_wr(1, 16'h0100);
    start_burst(1, 3);
    check("b1_valid0", bus.mem_valid, 64'd1);
    check("b1_addr0", bus.mem_addr, 16'h0100);
    check("b1_busy", bus.burst_busy, 64'd1);
    tick();
    check("b1_hold_addr", bus.mem_addr, 16'h0100);
    addr_q.push_back(16'h0100); addr_q.push_back(16'h0101); addr_q.push_back(16'h0102);
    bus.mem_ready = 1'b1;
    tick(); tick(); tick();
    bus.mem_ready = 1'b0;
    check("b1_done", bus.burst_done, 64'd1);
    check("b1_busy_done", bus.burst_busy, 64'd1);
    check("b1_valid_done", bus.mem_valid, 64'd0);
    tick();
    check("b1_done_clear", bus.burst_done, 64'd0);
    check("b1_busy_clear", bus.burst_busy, 64'd0);
    check("b1_final_ch1", chan(1), 16'h0103);
    check("b1_done_count", done_cnt, 64'd1);

    // burst_start during RUN is ignored
    do_wr(0, 16'h0040);
    start_burst(0, 2);
    bus.burst_start = 1'b1; bus.burst_sel = 2'd1; bus.burst_len = 8'd5;
    addr_q.push_back(16'h0040); addr_q.push_back(16'h0041);
    bus.mem_ready = 1'b1;
    tick(); tick();
    bus.burst_start = 1'b0;
    bus.mem_ready = 1'b0;
    check("b2_done", bus.burst_done, 64'd1);
    tick();
    check("b2_idle", bus.burst_busy, 64'd0);
    check("b2_no_restart", bus.mem_valid, 64'd0);
    check("b2_ch0", chan(0), 16'h0042);
    check("b2_ch1_untouched", chan(1), 16'h0103);
    check("b2_done_count", done_cnt, 64'd2);

    // Zero-length burst
    do_wr(3, 16'h0777);
    start_burst(3, 0);
    check("z_done", bus.burst_done, 64'd1);
    check("z_valid", bus.mem_valid, 64'd0);
    tick();
    check("z_done_clear", bus.burst_done, 64'd0);
    check("z_idle", bus.burst_busy, 64'd0);
    check("z_ch3", chan(3), 16'h0777);
    check("z_done_count", done_cnt, 64'd3);

    // Reset mid-burst
    do_wr(2, 16'h0200);
    start_burst(2, 4);
    addr_q.push_back(16'h0200); addr_q.push_back(16'h0201);
    bus.mem_ready = 1'b1;
    tick(); tick();
    #2 Reset = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    check("mrst_ch2", chan(2), 16'h0000);
    check("mrst_busy", bus.burst_busy, 64'd0);
    check("mrst_valid", bus.mem_valid, 64'd0);
    tick();
    Reset = 1'b0;
    tick();
    check("mrst_no_done", done_cnt, 64'd3);

    // Write to active channel mid-burst
    do_wr(2, 16'h0200);
    start_burst(2, 4);
    addr_q.push_back(16'h0200);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    do_wr(2, 16'h0800);
    check("wmid_ch2", chan(2), 16'h0800);
    check("wmid_addr", bus.mem_addr, 16'h0800);
    addr_q.push_back(16'h0800); addr_q.push_back(16'h0801); addr_q.push_back(16'h0802);
    bus.mem_ready = 1'b1;
    tick(); tick(); tick();
    bus.mem_ready = 1'b0;
    check("wmid_done", bus.burst_done, 64'd1);
    tick();
    check("wmid_final_ch2", chan(2), 16'h0803);
    check("wmid_done_count", done_cnt, 64'd4);

    check("queue_drained", addr_q.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
